// File: rtl/exp_table_loader_if.sv
// rtl/exp_table_loader_if.sv - coefficient stream input and MAC table write port
// The loader uses the slave view; the coefficient source and the MAC table side use master.
interface exp_table_loader_if #(
  parameter int BASE_W   = 16,
  parameter int OFFSET_W = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [BASE_W+OFFSET_W-1:0]   in_data;
  logic                         cfg_w_en;
  logic                         cfg_sgn;
  logic [3:0]                   cfg_idx;
  logic [BASE_W-1:0]            cfg_base;
  logic [OFFSET_W-1:0]          cfg_offset;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  cfg_w_en,
    input  cfg_sgn,
    input  cfg_idx,
    input  cfg_base,
    input  cfg_offset
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output cfg_w_en,
    output cfg_sgn,
    output cfg_idx,
    output cfg_base,
    output cfg_offset
  );
endinterface

// File: rtl/exp_table_loader.sv
// rtl/exp_table_loader.sv - sequences 2 x N_IDX coefficient writes into the exp MAC table
// Each accepted {base, offset} word becomes one registered cfg write, sign 0 first.
module exp_table_loader #(
  parameter int BASE_W   = 16,
  parameter int OFFSET_W = 16,
  parameter int N_IDX    = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  exp_table_loader_if.slave          bus,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 loaded,
  output logic [BASE_W+OFFSET_W-1:0] checksum
);
  localparam int DW = BASE_W + OFFSET_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [3:0] IDX_LAST = 4'(N_IDX - 1);

  logic [0:0]          state_q, state_d;
  logic                ptr_sgn_q, ptr_sgn_d;
  logic [3:0]          ptr_idx_q, ptr_idx_d;
  logic [4:0]          loaded_q, loaded_d;
  logic [DW-1:0]       checksum_q, checksum_d;
  logic                done_q, done_d;
  logic                cfg_w_en_q, cfg_w_en_d;
  logic                cfg_sgn_q, cfg_sgn_d;
  logic [3:0]          cfg_idx_q, cfg_idx_d;
  logic [BASE_W-1:0]   cfg_base_q, cfg_base_d;
  logic [OFFSET_W-1:0] cfg_offset_q, cfg_offset_d;

  logic in_ready;
  logic handshake;
  logic ptr_last;

  // Abort drops ready in the same cycle so a word presented alongside it is never consumed.
  assign in_ready  = (state_q == ST_LOAD) && !abort;
  assign handshake = bus.in_valid && in_ready;
  assign ptr_last  = ptr_sgn_q && (ptr_idx_q == IDX_LAST);

  always_comb begin
    state_d      = state_q;
    ptr_sgn_d    = ptr_sgn_q;
    ptr_idx_d    = ptr_idx_q;
    loaded_d     = loaded_q;
    checksum_d   = checksum_q;
    done_d       = 1'b0;
    cfg_w_en_d   = 1'b0;
    cfg_sgn_d    = cfg_sgn_q;
    cfg_idx_d    = cfg_idx_q;
    cfg_base_d   = cfg_base_q;
    cfg_offset_d = cfg_offset_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_LOAD;
          ptr_sgn_d  = 1'b0;
          ptr_idx_d  = 4'd0;
          loaded_d   = 5'd0;
          checksum_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          cfg_w_en_d   = 1'b1;
          cfg_sgn_d    = ptr_sgn_q;
          cfg_idx_d    = ptr_idx_q;
          cfg_base_d   = bus.in_data[DW-1:OFFSET_W];
          cfg_offset_d = bus.in_data[OFFSET_W-1:0];
          loaded_d     = loaded_q + 5'd1;
          checksum_d   = checksum_q ^ bus.in_data;
          if (ptr_idx_q == IDX_LAST) begin
            ptr_idx_d = 4'd0;
            ptr_sgn_d = 1'b1;
          end else begin
            ptr_idx_d = ptr_idx_q + 4'd1;
          end
          if (ptr_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_sgn_q    <= 1'b0;
      ptr_idx_q    <= 4'd0;
      loaded_q     <= 5'd0;
      checksum_q   <= '0;
      done_q       <= 1'b0;
      cfg_w_en_q   <= 1'b0;
      cfg_sgn_q    <= 1'b0;
      cfg_idx_q    <= 4'd0;
      cfg_base_q   <= '0;
      cfg_offset_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_sgn_q    <= ptr_sgn_d;
      ptr_idx_q    <= ptr_idx_d;
      loaded_q     <= loaded_d;
      checksum_q   <= checksum_d;
      done_q       <= done_d;
      cfg_w_en_q   <= cfg_w_en_d;
      cfg_sgn_q    <= cfg_sgn_d;
      cfg_idx_q    <= cfg_idx_d;
      cfg_base_q   <= cfg_base_d;
      cfg_offset_q <= cfg_offset_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.cfg_w_en   = cfg_w_en_q;
  assign bus.cfg_sgn    = cfg_sgn_q;
  assign bus.cfg_idx    = cfg_idx_q;
  assign bus.cfg_base   = cfg_base_q;
  assign bus.cfg_offset = cfg_offset_q;
  assign busy           = (state_q == ST_LOAD);
  assign done           = done_q;
  assign loaded         = loaded_q;
  assign checksum       = checksum_q;
endmodule

// File: tb/tb_exp_table_loader.sv
// tb/tb_exp_table_loader.sv - bench for exp_table_loader
// Transaction-level reference model plus a vector table and directed load sequences.
module tb_exp_table_loader;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    loaded;
  logic [DW-1:0] checksum;

  int n_cmp = 0;
  int n_fail = 0;

  exp_table_loader_if #(.BASE_W(16), .OFFSET_W(16)) bus ();

  exp_table_loader #(.BASE_W(16), .OFFSET_W(16), .N_IDX(13)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .loaded   (loaded),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // Reference model: a load is just "the k-th accepted word goes to (k/13, k%13)".
  bit            m_active;
  int            m_count;
  logic [DW-1:0] m_xor;
  bit            m_wen, m_done;
  logic          m_sgn;
  logic [3:0]    m_idx;
  logic [15:0]   m_base, m_off;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_count = 0; m_xor = '0; m_wen = 0; m_done = 0;
    m_sgn = 0; m_idx = 0; m_base = 0; m_off = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, DW'(bus.in_ready), 0);
    chk({tag, "_w_en"},     DW'(bus.cfg_w_en), 0);
    chk({tag, "_sgn"},      DW'(bus.cfg_sgn), 0);
    chk({tag, "_idx"},      DW'(bus.cfg_idx), 0);
    chk({tag, "_base"},     DW'(bus.cfg_base), 0);
    chk({tag, "_offset"},   DW'(bus.cfg_offset), 0);
    chk({tag, "_busy"},     DW'(busy), 0);
    chk({tag, "_done"},     DW'(done), 0);
    chk({tag, "_loaded"},   DW'(loaded), 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // Called at posedge+1; drives inputs, checks ready mid-cycle, then checks registered outputs after the edge.
  task automatic cycle(input logic s, input logic a, input logic v, input logic [DW-1:0] d,
                       output logic rdy_seen);
    start = s; abort = a; bus.in_valid = v; bus.in_data = d;
    #2;
    rdy_seen = bus.in_ready;
    chk("in_ready", DW'(bus.in_ready), DW'(m_active && !a));
    @(posedge clk); #1;
    m_wen = 0; m_done = 0;
    if (m_active) begin
      if (a) begin
        m_active = 0;
      end else if (v) begin
        m_sgn  = (m_count >= 13);
        m_idx  = 4'(m_count % 13);
        m_base = d[31:16];
        m_off  = d[15:0];
        m_wen  = 1;
        m_count++;
        m_xor ^= d;
        if (m_count == 26) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end else if (s && !a) begin
      m_active = 1; m_count = 0; m_xor = '0;
    end
    chk("busy", DW'(busy), DW'(m_active));
    chk("done", DW'(done), DW'(m_done));
    chk("cfg_w_en", DW'(bus.cfg_w_en), DW'(m_wen));
    chk("cfg_sgn", DW'(bus.cfg_sgn), DW'(m_sgn));
    chk("cfg_idx", DW'(bus.cfg_idx), DW'(m_idx));
    chk("cfg_base", DW'(bus.cfg_base), DW'(m_base));
    chk("cfg_offset", DW'(bus.cfg_offset), DW'(m_off));
    chk("loaded", DW'(loaded), DW'(m_count));
    chk("checksum", checksum, m_xor);
  endtask

  function automatic logic [DW-1:0] plan_word(input int k);
    return {16'h0100 + 16'(k), 16'h0200 + 16'(k)};
  endfunction

  typedef struct {
    logic          s, a, v;
    logic [DW-1:0] d;
    logic          e_rdy, e_busy, e_wen;
    logic [4:0]    e_loaded;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic rdy;
    logic [DW-1:0] xr;
    int cyc;
    bit seen_done;

    bus.in_valid = 0;
    bus.in_data = '0;
    model_reset();

    @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1;

    vecs[0] = '{1, 1, 0, 32'h0,        0, 0, 0, 5'd0};
    vecs[1] = '{1, 0, 0, 32'h0,        0, 1, 0, 5'd0};
    vecs[2] = '{0, 0, 1, 32'hAAAA5555, 1, 1, 1, 5'd1};
    vecs[3] = '{0, 1, 1, 32'h12345678, 0, 0, 0, 5'd1};
    vecs[4] = '{0, 0, 1, 32'h0F0F0F0F, 0, 0, 0, 5'd1};
    vecs[5] = '{1, 1, 0, 32'h0,        0, 0, 0, 5'd1};
    vecs[6] = '{1, 0, 0, 32'h0,        0, 1, 0, 5'd0};
    vecs[7] = '{1, 0, 1, 32'hDEADBEEF, 1, 1, 1, 5'd1};
    vecs[8] = '{0, 1, 0, 32'h0,        0, 0, 0, 5'd1};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].d, rdy);
      chk($sformatf("vec%0d_rdy", i), DW'(rdy), DW'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), DW'(busy), DW'(vecs[i].e_busy));
      chk($sformatf("vec%0d_wen", i), DW'(bus.cfg_w_en), DW'(vecs[i].e_wen));
      chk($sformatf("vec%0d_loaded", i), DW'(loaded), DW'(vecs[i].e_loaded));
    end

    // Full load, valid held high: 27 cycles start-to-done.
    cycle(1, 0, 0, '0, rdy);
    xr = '0;
    seen_done = 0;
    for (int k = 0; k < 26; k++) begin
      cycle(0, 0, 1, plan_word(k), rdy);
      xr ^= plan_word(k);
      if (k == 13) begin
        chk("k13_base", DW'(bus.cfg_base), 32'h010D);
        chk("k13_sgn", DW'(bus.cfg_sgn), 1);
        chk("k13_idx", DW'(bus.cfg_idx), 0);
      end
      if (done) seen_done = (k == 25);
    end
    chk("full_done_at_27", DW'(seen_done), 1);
    chk("full_loaded", DW'(loaded), 26);
    chk("full_checksum", checksum, xr);
    cycle(0, 0, 0, '0, rdy);
    chk("full_done_low", DW'(done), 0);

    // Valid toggling every other cycle.
    cycle(1, 0, 0, '0, rdy);
    cyc = 0;
    seen_done = 0;
    while (!seen_done && cyc < 100) begin
      cycle(0, 0, cyc[0], plan_word(m_count), rdy);
      seen_done = done;
      cyc++;
    end
    chk("toggle_done", DW'(seen_done), 1);
    chk("toggle_loaded", DW'(loaded), 26);

    // Abort after 5 words while valid is high.
    cycle(1, 0, 0, '0, rdy);
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, plan_word(k), rdy);
    cycle(0, 1, 1, plan_word(5), rdy);
    chk("abort_rdy", DW'(rdy), 0);
    chk("abort_busy", DW'(busy), 0);
    chk("abort_loaded", DW'(loaded), 5);
    cycle(0, 0, 1, plan_word(6), rdy);
    chk("abort_no_done", DW'(done), 0);

    // Start pulsed during a load is ignored.
    cycle(1, 0, 0, '0, rdy);
    for (int k = 0; k < 26; k++) cycle((k == 10), 0, 1, plan_word(k), rdy);
    chk("restart_ignored_loaded", DW'(loaded), 26);
    chk("restart_ignored_done", DW'(done), 1);

    // Reset mid-load after 8 words.
    cycle(1, 0, 0, '0, rdy);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, plan_word(k), rdy);
    #2 rst_n = 0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    cycle(1, 0, 0, '0, rdy);
    cycle(0, 0, 1, plan_word(0), rdy);
    chk("post_rst_idx", DW'(bus.cfg_idx), 0);
    chk("post_rst_loaded", DW'(loaded), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0), $urandom, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
